alu_mp_sequencer: RTL and testbench

Multi-cycle sequencer that shares the 16-bit ALU (`A`, `B`, `ALU_CTRL`, `Cin_Ctrl` → `S`, `NZVC`) to perform 16- or 32-bit add/subtract, with or without carry. It sits between the control unit and the ALU. It owns the architectural NZVC flag register and chains carry between low and high passes. It issues a single-cycle `DONE` with registered result and flags.

---
 rtl/alu_mp_sequencer_if.sv | 28 ++
 rtl/alu_mp_sequencer.sv | 128 ++++++++++++
 tb/tb_alu_mp_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_mp_sequencer_if.sv
// ----------------------------------------------------------------------------
// alu_mp_sequencer_if
// Bus between the multi-pass sequencer and the shared 16-bit ALU.
//   ALU_A, ALU_B : ALU operands (driven by the sequencer)
//   ALU_CTRL     : 1 = subtract (B inverted), 0 = add
//   Cin_Ctrl     : carry-in control; ALU carry-in = ALU_CTRL ^ Cin_Ctrl
//   ALU_S        : ALU sum (combinational from the inputs above)
//   ALU_NZVC     : ALU flags {N,Z,V,C}, C = carry out of bit 15
// Modports: master = sequencer side, slave = ALU side.
// ----------------------------------------------------------------------------
interface alu_mp_sequencer_if;
    logic [15:0] ALU_A;
    logic [15:0] ALU_B;
    logic        ALU_CTRL;
    logic        Cin_Ctrl;
    logic [15:0] ALU_S;
    logic [3:0]  ALU_NZVC;

    modport master (
        output ALU_A, ALU_B, ALU_CTRL, Cin_Ctrl,
        input  ALU_S, ALU_NZVC
    );

    modport slave (
        input  ALU_A, ALU_B, ALU_CTRL, Cin_Ctrl,
        output ALU_S, ALU_NZVC
    );
endinterface

// File: rtl/alu_mp_sequencer.sv
// ----------------------------------------------------------------------------
// alu_mp_sequencer
// Runs 16-bit (one pass) or 32-bit (two passes, carry chained) add/subtract,
// with or without carry-in from the flag register, on a shared 16-bit ALU.
// Owns the architectural NZVC register.
//   CLK, RESET     : clock, synchronous active-high reset
//   START          : request, accepted when BUSY = 0
//   OP             : 00 ADD, 01 SUB, 10 ADC, 11 SBC (sampled with START)
//   WIDE           : 1 = 32-bit, 0 = 16-bit (sampled with START)
//   A_IN, B_IN     : operands (sampled with START), narrow uses [15:0]
//   FLAG_LD/FLAG_D : load NZVC register while idle
//   BUSY, DONE     : operation in progress / one-cycle completion pulse
//   RESULT, FLAGS  : registered result and NZVC
//   alu            : ALU bus (master side)
//
// state | meaning
// IDLE  | waiting for START, FLAG_LD accepted
// LO    | ALU driven with low halves
// HI    | ALU driven with high halves, carry chained from LO
// FIN   | DONE high, BUSY low; a new START is accepted here
// ----------------------------------------------------------------------------
module alu_mp_sequencer (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        START,
    input  logic [1:0]  OP,
    input  logic        WIDE,
    input  logic [31:0] A_IN,
    input  logic [31:0] B_IN,
    input  logic        FLAG_LD,
    input  logic [3:0]  FLAG_D,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] RESULT,
    output logic [3:0]  FLAGS,
    alu_mp_sequencer_if.master alu
);

    typedef enum logic [1:0] {IDLE, LO, HI, FIN} state_t;

    state_t      state;
    logic        wide_q;
    logic [15:0] a_hi;
    logic [15:0] b_hi;
    logic [15:0] s_lo;
    logic        z_lo;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= IDLE;
            wide_q       <= 1'b0;
            a_hi         <= '0;
            b_hi         <= '0;
            s_lo         <= '0;
            z_lo         <= 1'b0;
            BUSY         <= 1'b0;
            DONE         <= 1'b0;
            RESULT       <= '0;
            FLAGS        <= '0;
            alu.ALU_A    <= '0;
            alu.ALU_B    <= '0;
            alu.ALU_CTRL <= 1'b0;
            alu.Cin_Ctrl <= 1'b0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    DONE <= 1'b0;
                    if (START) begin
                        state        <= LO;
                        BUSY         <= 1'b1;
                        wide_q       <= WIDE;
                        a_hi         <= A_IN[31:16];
                        b_hi         <= B_IN[31:16];
                        alu.ALU_A    <= A_IN[15:0];
                        alu.ALU_B    <= B_IN[15:0];
                        alu.ALU_CTRL <= OP[0];
                        // ADC/SBC take carry-in from the current C flag, so
                        // Cin_Ctrl is chosen to make ALU_CTRL ^ Cin_Ctrl = C.
                        alu.Cin_Ctrl <= OP[1] & (OP[0] ^ FLAGS[0]);
                    end else begin
                        state <= IDLE;
                        if (FLAG_LD && state == IDLE) begin
                            FLAGS <= FLAG_D;
                        end
                    end
                end

                LO: begin
                    s_lo <= alu.ALU_S;
                    z_lo <= alu.ALU_NZVC[2];
                    if (wide_q) begin
                        state        <= HI;
                        alu.ALU_A    <= a_hi;
                        alu.ALU_B    <= b_hi;
                        // Cin_Ctrl holds the low-pass carry for the HI pass.
                        alu.Cin_Ctrl <= alu.ALU_CTRL ^ alu.ALU_NZVC[0];
                    end else begin
                        state        <= FIN;
                        RESULT       <= {16'h0000, alu.ALU_S};
                        FLAGS        <= alu.ALU_NZVC;
                        DONE         <= 1'b1;
                        BUSY         <= 1'b0;
                        alu.ALU_A    <= '0;
                        alu.ALU_B    <= '0;
                        alu.ALU_CTRL <= 1'b0;
                        alu.Cin_Ctrl <= 1'b0;
                    end
                end

                HI: begin
                    state        <= FIN;
                    RESULT       <= {alu.ALU_S, s_lo};
                    FLAGS        <= {alu.ALU_NZVC[3], z_lo & alu.ALU_NZVC[2],
                                     alu.ALU_NZVC[1:0]};
                    DONE         <= 1'b1;
                    BUSY         <= 1'b0;
                    alu.ALU_A    <= '0;
                    alu.ALU_B    <= '0;
                    alu.ALU_CTRL <= 1'b0;
                    alu.Cin_Ctrl <= 1'b0;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mp_sequencer.sv
// ----------------------------------------------------------------------------
// tb_alu_mp_sequencer
// Self-checking bench for alu_mp_sequencer. Provides a behavioural 16-bit ALU
// on the bus interface and a 32/16-bit reference model whose results are
// queued at issue time and compared when DONE is seen.
// ----------------------------------------------------------------------------
module tb_alu_mp_sequencer;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic [1:0]  OP = 2'b00;
    logic        WIDE = 1'b0;
    logic [31:0] A_IN = '0;
    logic [31:0] B_IN = '0;
    logic        FLAG_LD = 1'b0;
    logic [3:0]  FLAG_D = '0;
    logic        BUSY;
    logic        DONE;
    logic [31:0] RESULT;
    logic [3:0]  FLAGS;

    alu_mp_sequencer_if alu_bus();

    alu_mp_sequencer dut (
        .CLK(CLK), .RESET(RESET), .START(START), .OP(OP), .WIDE(WIDE),
        .A_IN(A_IN), .B_IN(B_IN), .FLAG_LD(FLAG_LD), .FLAG_D(FLAG_D),
        .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .FLAGS(FLAGS),
        .alu(alu_bus)
    );

    always #5 CLK = ~CLK;

    // Behavioural ALU
    logic [15:0] alu_bx;
    logic        alu_cin;
    logic [16:0] alu_sum;
    always_comb begin
        alu_bx  = alu_bus.ALU_CTRL ? ~alu_bus.ALU_B : alu_bus.ALU_B;
        alu_cin = alu_bus.ALU_CTRL ^ alu_bus.Cin_Ctrl;
        alu_sum = {1'b0, alu_bus.ALU_A} + {1'b0, alu_bx} + {16'b0, alu_cin};
    end
    assign alu_bus.ALU_S    = alu_sum[15:0];
    assign alu_bus.ALU_NZVC = {alu_sum[15], alu_sum[15:0] == 16'h0000,
                               (alu_bus.ALU_A[15] == alu_bx[15]) && (alu_sum[15] != alu_bus.ALU_A[15]),
                               alu_sum[16]};

    typedef struct packed {
        logic [31:0] result;
        logic [3:0]  flags;
        logic        wide;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] model_flags = '0;
    int         checks = 0;
    int         failures = 0;

    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, ADC = 2'b10, SBC = 2'b11;

    function automatic exp_t model(input logic [1:0] op, input logic wide,
                                   input logic [31:0] a, input logic [31:0] b,
                                   input logic cf);
        exp_t        e;
        logic        sub, cin;
        logic [31:0] bx;
        logic [32:0] s33;
        logic [15:0] bx16;
        logic [16:0] s17;
        sub = op[0];
        cin = op[1] ? cf : sub;
        e.wide = wide;
        if (wide) begin
            bx  = sub ? ~b : b;
            s33 = {1'b0, a} + {1'b0, bx} + {32'b0, cin};
            e.result = s33[31:0];
            e.flags  = {s33[31], s33[31:0] == 32'h0,
                        (a[31] == bx[31]) && (s33[31] != a[31]), s33[32]};
        end else begin
            bx16 = sub ? ~b[15:0] : b[15:0];
            s17  = {1'b0, a[15:0]} + {1'b0, bx16} + {16'b0, cin};
            e.result = {16'h0000, s17[15:0]};
            e.flags  = {s17[15], s17[15:0] == 16'h0,
                        (a[15] == bx16[15]) && (s17[15] != a[15]), s17[16]};
        end
        return e;
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Drive START for one edge and queue the expected outcome.
    task automatic issue(input logic [1:0] op, input logic wide,
                         input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e = model(op, wide, a, b, model_flags[0]);
        sb.push_back(e);
        model_flags = e.flags;
        OP = op; WIDE = wide; A_IN = a; B_IN = b; START = 1'b1;
        step();
        START = 1'b0;
        A_IN = $urandom; B_IN = $urandom; OP = 2'($urandom); WIDE = 1'($urandom);
    endtask

    task automatic flag_load(input logic [3:0] v);
        FLAG_LD = 1'b1; FLAG_D = v;
        step();
        FLAG_LD = 1'b0;
        model_flags = v;
    endtask

    task automatic wait_done(input int max, output int n, output bit ok);
        ok = 1'b0;
        n = 0;
        for (int i = 1; i <= max; i++) begin
            step();
            if (DONE === 1'b1) begin
                ok = 1'b1;
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        step(); step();
        RESET = 1'b0;
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
        checks++; if (DONE !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", DONE); end
        checks++; if (RESULT !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", RESULT); end
        checks++; if (FLAGS !== 4'h0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", FLAGS); end
        checks++;
        if ({alu_bus.ALU_A, alu_bus.ALU_B, alu_bus.ALU_CTRL, alu_bus.Cin_Ctrl} !== 34'h0) begin
            failures++;
            $display("FAIL reset_alu_bus got=%h/%h/%b/%b exp=0", alu_bus.ALU_A, alu_bus.ALU_B,
                     alu_bus.ALU_CTRL, alu_bus.Cin_Ctrl);
        end
        model_flags = '0;
        sb.delete();
    endtask

    task automatic test_wide_add();
        exp_t e; int n; bit ok;
        issue(ADD, 1'b1, 32'h0000FFFF, 32'h00000001);
        checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL wadd_busy got=%b exp=1", BUSY); end
        checks++; if (alu_bus.ALU_A !== 16'hFFFF || alu_bus.Cin_Ctrl !== 1'b0) begin
            failures++; $display("FAIL wadd_lo_drive got=%h/%b exp=ffff/0", alu_bus.ALU_A, alu_bus.Cin_Ctrl); end
        step();
        checks++; if (alu_bus.ALU_A !== 16'h0000 || alu_bus.Cin_Ctrl !== 1'b1) begin
            failures++; $display("FAIL wadd_hi_drive got=%h/%b exp=0000/1", alu_bus.ALU_A, alu_bus.Cin_Ctrl); end
        wait_done(4, n, ok);
        checks++;
        if (!ok || n != 1) begin failures++; $display("FAIL wadd_latency ok=%0d edges_after_hi=%0d exp=1", ok, n); end
        else begin
            e = sb.pop_front();
            checks++; if (RESULT !== e.result || RESULT !== 32'h00010000) begin
                failures++; $display("FAIL wadd_result got=%h exp=00010000", RESULT); end
            checks++; if (FLAGS !== e.flags || FLAGS !== 4'b0000) begin
                failures++; $display("FAIL wadd_flags got=%b exp=0000", FLAGS); end
            checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL wadd_busy_fin got=%b exp=0", BUSY); end
        end
        step();
        checks++; if (DONE !== 1'b0) begin failures++; $display("FAIL wadd_done_pulse got=%b exp=0", DONE); end
    endtask

    task automatic test_wide_table();
        logic [1:0]  t_op  [4] = '{SUB, ADD, ADD, ADD};
        logic [31:0] t_a   [4] = '{32'h00000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00010000};
        logic [31:0] t_b   [4] = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h00000000};
        logic [31:0] t_res [4] = '{32'hFFFFFFFF, 32'h80000000, 32'h00000000, 32'h00010000};
        logic [3:0]  t_flg [4] = '{4'b1000, 4'b1010, 4'b0101, 4'b0000};
        exp_t e; int n; bit ok;
        for (int i = 0; i < 4; i++) begin
            issue(t_op[i], 1'b1, t_a[i], t_b[i]);
            wait_done(5, n, ok);
            checks++;
            if (!ok || n != 2) begin failures++; $display("FAIL wide_latency[%0d] ok=%0d edges=%0d exp=2", i, ok, n); end
            else begin
                e = sb.pop_front();
                checks++; if (RESULT !== e.result || RESULT !== t_res[i]) begin
                    failures++; $display("FAIL wide_result[%0d] got=%h exp=%h", i, RESULT, t_res[i]); end
                checks++; if (FLAGS !== e.flags || FLAGS !== t_flg[i]) begin
                    failures++; $display("FAIL wide_flags[%0d] got=%b exp=%b", i, FLAGS, t_flg[i]); end
            end
            step();
        end
    endtask

    task automatic test_carry_ops();
        exp_t e; int n; bit ok;
        flag_load(4'b0001);
        checks++; if (FLAGS !== 4'b0001) begin failures++; $display("FAIL flag_ld got=%b exp=0001", FLAGS); end
        issue(ADC, 1'b0, 32'h0000FFFF, 32'h00000005);
        wait_done(4, n, ok);
        checks++;
        if (!ok || n != 1) begin failures++; $display("FAIL adc_latency ok=%0d edges=%0d exp=1", ok, n); end
        else begin
            e = sb.pop_front();
            checks++; if (RESULT !== e.result || RESULT !== 32'h00000005) begin
                failures++; $display("FAIL adc_result got=%h exp=00000005", RESULT); end
            checks++; if (FLAGS !== e.flags || FLAGS !== 4'b0001) begin
                failures++; $display("FAIL adc_flags got=%b exp=0001", FLAGS); end
        end
        step();
        flag_load(4'b0000);
        issue(SBC, 1'b0, 32'h0000FFFF, 32'h00000005);
        wait_done(4, n, ok);
        checks++;
        if (!ok || n != 1) begin failures++; $display("FAIL sbc_latency ok=%0d edges=%0d exp=1", ok, n); end
        else begin
            e = sb.pop_front();
            checks++; if (RESULT !== e.result || RESULT !== 32'h0000FFF9) begin
                failures++; $display("FAIL sbc_result got=%h exp=0000fff9", RESULT); end
            checks++; if (FLAGS !== e.flags || FLAGS !== 4'b1001) begin
                failures++; $display("FAIL sbc_flags got=%b exp=1001", FLAGS); end
        end
        step();
    endtask

    task automatic test_ignored_start();
        exp_t e; int dones;
        issue(ADD, 1'b1, 32'h12345678, 32'h11111111);
        START = 1'b1; OP = SUB; A_IN = 32'hDEADBEEF; B_IN = 32'h0BADF00D;
        step();
        step();
        START = 1'b0;
        checks++;
        if (DONE !== 1'b1) begin failures++; $display("FAIL ign_done got=%b exp=1", DONE); end
        else begin
            e = sb.pop_front();
            checks++; if (RESULT !== e.result || RESULT !== 32'h23456789) begin
                failures++; $display("FAIL ign_result got=%h exp=23456789", RESULT); end
        end
        dones = 0;
        for (int i = 0; i < 4; i++) begin step(); if (DONE === 1'b1) dones++; end
        checks++; if (dones != 0 || BUSY !== 1'b0) begin
            failures++; $display("FAIL ign_extra_done got=%0d busy=%b exp=0/0", dones, BUSY); end
    endtask

    task automatic test_flag_ld_busy();
        exp_t e; logic [3:0] old;
        flag_load(4'b0101);
        old = model_flags;
        issue(ADD, 1'b1, 32'h00000001, 32'h00000001);
        FLAG_LD = 1'b1; FLAG_D = 4'b1110;
        step();
        checks++; if (FLAGS !== old) begin failures++; $display("FAIL fldbusy_hold got=%b exp=%b", FLAGS, old); end
        step();
        FLAG_LD = 1'b0;
        checks++;
        if (DONE !== 1'b1) begin failures++; $display("FAIL fldbusy_done got=%b exp=1", DONE); end
        else begin
            e = sb.pop_front();
            checks++; if (FLAGS !== e.flags || RESULT !== 32'h2) begin
                failures++; $display("FAIL fldbusy_fin got=%b/%h exp=%b/00000002", FLAGS, RESULT, e.flags); end
        end
        step();
    endtask

    task automatic test_start_flag_ld();
        exp_t e; int n; bit ok;
        flag_load(4'b0001);
        FLAG_LD = 1'b1; FLAG_D = 4'b0000;
        issue(ADC, 1'b0, 32'h00000001, 32'h00000001);
        FLAG_LD = 1'b0;
        wait_done(4, n, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL stfl_timeout got=none exp=done"); end
        else begin
            e = sb.pop_front();
            checks++; if (RESULT !== e.result || RESULT !== 32'h3) begin
                failures++; $display("FAIL stfl_result got=%h exp=00000003", RESULT); end
        end
        step();
    endtask

    task automatic test_back_to_back();
        exp_t e; int n; bit ok;
        logic [1:0] op; logic w;
        issue(2'($urandom), 1'($urandom), $urandom, $urandom);
        for (int i = 0; i < 16; i++) begin
            wait_done(5, n, ok);
            checks++;
            if (!ok) begin failures++; $display("FAIL b2b_timeout[%0d] got=none exp=done", i); break; end
            e = sb.pop_front();
            checks++; if (n != (e.wide ? 2 : 1) || BUSY !== 1'b0) begin
                failures++; $display("FAIL b2b_timing[%0d] edges=%0d busy=%b exp=%0d/0", i, n, BUSY, e.wide ? 2 : 1); end
            checks++; if (RESULT !== e.result || FLAGS !== e.flags) begin
                failures++; $display("FAIL b2b_data[%0d] got=%h/%b exp=%h/%b", i, RESULT, FLAGS, e.result, e.flags); end
            if (i < 15) begin
                op = 2'($urandom); w = 1'($urandom);
                issue(op, w, $urandom, $urandom);
            end
        end
        step();
    endtask

    task automatic test_reset_mid();
        exp_t e; int dones; int n; bit ok;
        flag_load(4'b1111);
        issue(ADD, 1'b1, 32'h11112222, 32'h33334444);
        step();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        sb.delete();
        model_flags = '0;
        checks++; if (BUSY !== 1'b0 || DONE !== 1'b0) begin
            failures++; $display("FAIL rstmid_ctrl got=%b/%b exp=0/0", BUSY, DONE); end
        checks++; if (FLAGS !== 4'h0 || RESULT !== 32'h0) begin
            failures++; $display("FAIL rstmid_data got=%b/%h exp=0000/0", FLAGS, RESULT); end
        dones = 0;
        for (int i = 0; i < 3; i++) begin step(); if (DONE === 1'b1) dones++; end
        checks++; if (dones != 0) begin failures++; $display("FAIL rstmid_no_done got=%0d exp=0", dones); end
        issue(SUB, 1'b1, 32'h00050000, 32'h00000001);
        wait_done(5, n, ok);
        checks++;
        if (!ok || n != 2) begin failures++; $display("FAIL rstmid_after ok=%0d edges=%0d exp=2", ok, n); end
        else begin
            e = sb.pop_front();
            checks++; if (RESULT !== e.result || RESULT !== 32'h0004FFFF || FLAGS !== e.flags) begin
                failures++; $display("FAIL rstmid_after_data got=%h/%b exp=0004ffff/%b", RESULT, FLAGS, e.flags); end
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_wide_add();
        test_wide_table();
        test_carry_ops();
        test_ignored_start();
        test_flag_ld_busy();
        test_start_flag_ld();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
